// File: rtl/seq_mult16_ctrl.sv
// Sequential 16x16 shift-and-add multiplier time-sharing one 8-bit ripple adder.
// Optional build macro MULT_ZERO_SKIP_EN: bits with a zero multiplier bit go straight to SHIFT.

module FA8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

module seq_mult16_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_LO,
    S_ADD_HI,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] mcand;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        cy_lo;
  logic        cy_hi;

  logic [7:0]  fa_a;
  logic [7:0]  fa_b;
  logic        fa_cin;
  logic [7:0]  fa_sum;
  logic        fa_cout;
  logic [31:0] acc_sh;
  logic        last_bit;
  logic        skip_first;
  logic        skip_next;

  assign acc_sh   = {cy_hi, acc[31:1]};
  assign last_bit = (cnt == 5'd15);

`ifdef MULT_ZERO_SKIP_EN
  // acc[1] becomes the next bit's acc[0] after this shift
  assign skip_first = ~b[0];
  assign skip_next  = ~acc[1];
`else
  assign skip_first = 1'b0;
  assign skip_next  = 1'b0;
`endif

  always_comb begin
    fa_a   = acc[23:16];
    fa_b   = acc[0] ? mcand[7:0] : 8'h00;
    fa_cin = 1'b0;
    if (state == S_ADD_HI) begin
      fa_a   = acc[31:24];
      fa_b   = acc[0] ? mcand[15:8] : 8'h00;
      fa_cin = cy_lo;
    end
  end

  FA8bit u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_n = skip_first ? S_SHIFT : S_ADD_LO;
      end
      S_ADD_LO: state_n = S_ADD_HI;
      S_ADD_HI: state_n = S_SHIFT;
      S_SHIFT: begin
        if (last_bit)       state_n = S_DONE;
        else if (skip_next) state_n = S_SHIFT;
        else                state_n = S_ADD_LO;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      cy_lo   <= 1'b0;
      cy_hi   <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {16'h0000, b};
            cnt   <= '0;
            cy_hi <= 1'b0;
          end
        end
        S_ADD_LO: begin
          acc[23:16] <= fa_sum;
          cy_lo      <= fa_cout;
        end
        S_ADD_HI: begin
          acc[31:24] <= fa_sum;
          cy_hi      <= fa_cout;
        end
        S_SHIFT: begin
          acc   <= acc_sh;
          cy_hi <= 1'b0;
          cnt   <= cnt + 5'd1;
          // load on the edge into DONE so product is valid with the pulse
          if (last_bit)
            product <= acc_sh;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_ADD_LO) ||
                (state == S_ADD_HI) ||
                (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
